// File: rtl/fifo_param_if.sv
// fifo_param_if: write/read, threshold-init and status bundle for fifo_param.
// master drives requests; slave is the FIFO itself.
interface fifo_param_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
);
  logic              init;
  logic [ADDR_W:0]   umbral_superior;
  logic [ADDR_W:0]   umbral_inferior;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              error;

  modport master (
    output init, umbral_superior, umbral_inferior,
    output push, data_in, pop,
    input  data_out, valid_out, count,
    input  full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  init, umbral_superior, umbral_inferior,
    input  push, data_in, pop,
    output data_out, valid_out, count,
    output full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO for per-class TLP queues.
// Define FIFO_ERR_EN to build sticky overflow/underflow detection.
module fifo_param #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int AF_DEF = (1 << ADDR_W) - 1,
  parameter int AE_DEF = 1
) (
  input logic          clk,
  input logic          reset_L,
  fifo_param_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_DEF);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_DEF);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_af_thr;
  logic [ADDR_W:0]   r_ae_thr;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;

  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;

  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_pop_acc  = bus.pop && !w_empty;
  // a pop frees the head slot, so a full FIFO still takes the push
  assign w_push_acc = bus.push && (!w_full || w_pop_acc);

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_af_thr <= LP_AF;
      r_ae_thr <= LP_AE;
    end else begin
      r_valid <= w_pop_acc;
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_dout   <= r_mem[r_rd_ptr];
      end
      unique case (1'b1)
        w_push_acc && !w_pop_acc: r_count <= r_count + 1'b1;
        w_pop_acc && !w_push_acc: r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (bus.init) begin
        r_af_thr <= bus.umbral_superior;
        r_ae_thr <= bus.umbral_inferior;
      end
    end
  end

  assign bus.data_out     = r_dout;
  assign bus.valid_out    = r_valid;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= r_af_thr);
  assign bus.almost_empty = (r_count <= r_ae_thr);

`ifdef FIFO_ERR_EN
  logic r_error;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error <= 1'b0;
    end else if ((bus.push && !w_push_acc) || (bus.pop && w_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO for the PCIe transaction-layer datapath. It is the next-generation buffer for the per-class TLP queues between the arbiter stages. Data width and depth are set by parameters. It provides true full/empty flags, an occupancy count, and almost-full/almost-empty thresholds that are programmable at init. A same-cycle push and pop are accepted together, and a registered read port carries a valid strobe.

## Interface
Parameters:
- DATA_W, 10, data word width in bits
- ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W
- AF_DEF, DEPTH-1, almost-full threshold loaded at reset
- AE_DEF, 1, almost-empty threshold loaded at reset

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  when high at a clk edge, latches umbral_superior/umbral_inferior
- umbral_superior  in  ADDR_W+1  almost-full threshold (0..DEPTH)
- umbral_inferior  in  ADDR_W+1  almost-empty threshold (0..DEPTH)
- push  in  1  write request
- data_in  in  DATA_W  write data
- pop  in  1  read request
- data_out  out  DATA_W  registered read data
- valid_out  out  1  data_out carries a word popped on the previous edge
- count  out  ADDR_W+1  occupancy 0..DEPTH
- full, empty  out  1  count==DEPTH / count==0
- almost_full  out  1  count >= latched upper threshold
- almost_empty  out  1  count <= latched lower threshold
- error  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Storage: DEPTH x DATA_W array. wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count is ADDR_W+1 bits, so full and empty are never ambiguous.
- Push acceptance:
  - Accepted when push && (!full || pop_acc).
  - On acceptance: mem[wr_ptr] <= data_in and wr_ptr increments.
- Pop acceptance:
  - Accepted when pop && !empty.
  - On acceptance: data_out <= mem[rd_ptr], rd_ptr increments, and valid_out is 1 on the next cycle.
  - Otherwise valid_out is 0 and data_out holds its last value.
- count update:
  - +1 for push only, −1 for pop only.
  - Unchanged for both accepted or neither accepted.
- Push and pop together:
  - When full: both are accepted, count stays at DEPTH, and the popped word is the old head.
  - When empty: only the push is accepted (no bypass), count 0→1, valid_out 0.
- Rejected requests:
  - Push while full without pop is dropped (overflow).
  - Pop while empty is ignored (underflow).
  - Neither changes pointers or count.
- Thresholds:
  - Latched into internal registers on any edge where init=1; they take effect the cycle after the latch.
  - Values above DEPTH are legal: almost_full never asserts, and almost_empty is always asserted.
- Flags: full, empty, almost_full and almost_empty are combinational from the registered count and the latched thresholds.

## Timing
- Reset (reset_L low, asynchronous): immediately sets the following. Memory contents are not cleared.
  - wr_ptr=rd_ptr=0, count=0
  - data_out=0, valid_out=0
  - empty=1, full=0
  - thresholds loaded to AF_DEF/AE_DEF, so almost_empty=1 and almost_full=0
  - error=0
- Reset mid-operation discards all queued words. After release, the first push takes effect at the next clk edge.
- Write latency: a word pushed at edge N is poppable at edge N+1, and appears on data_out with valid_out=1 after edge N+1.
- Read latency: 1 cycle from the accepting edge to data_out/valid_out.
- Throughput: one push and one pop per cycle sustained.
- Flags and count reflect all accepted operations from the most recent edge.

## Configuration
- FIFO_ERR_EN defined:
  - error is set on any rejected push (overflow) or rejected pop (underflow).
  - error stays set until reset_L is asserted.
- FIFO_ERR_EN undefined: error is tied to 0, no detection logic is built, and rejected requests are silently dropped as above.

## Test plan
- Reset then 8 pushes (0x001..0x008), DATA_W=10, ADDR_W=3 → count 1..8; full=1 after the 8th; almost_full=1 from count 7; empty=0 after the 1st.
- Pop 8 times from full → data_out 0x001..0x008 each one cycle after its pop, with valid_out=1; empty=1 and almost_empty=1 at count≤1.
- Fill to 8, then push 0x3FF and pop together for 4 cycles → count stays 8; outputs 0x001..0x004; 0x3FF appears later in order; with FIFO_ERR_EN, error=0.
- Push when full without pop, and pop when empty → count and pointers unchanged, valid_out=0; error=1 with FIFO_ERR_EN and 0 without.
- init=1 with umbral_superior=4, umbral_inferior=2, then push 4 → almost_empty deasserts at count 3; almost_full asserts at count 4.
- Drive reset_L low mid-stream with count=5 → all outputs return to reset values without waiting for a clk edge; after release, push 0x055 and pop → data_out=0x055.
